branch_resolution_queue: RTL and testbench

In-order queue that sits directly downstream of the perceptron branch predictor. It captures each issued prediction together with its instruction pointer, and holds it until the branch resolves in program order. On resolution it emits a one-cycle training record (ip, actual outcome, mispredict flag) for the predictor's update path, and it keeps running accuracy counters.

---
 rtl/branch_resolution_queue.sv | 91 +++++++++
 tb/tb_branch_resolution_queue.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/branch_resolution_queue.sv
// branch_resolution_queue: in-order queue of predictions, emits training records and accuracy stats on resolve
module branch_resolution_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int IP_W  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_valid,
  input  logic [IP_W-1:0]  pred_ip,
  input  logic             pred_taken,
  output logic             pred_ready,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  input  logic             flush,
  output logic             train_valid,
  output logic [IP_W-1:0]  train_ip,
  output logic             train_taken,
  output logic             train_mispredict,
  output logic [PTR_W:0]   occupancy,
  output logic [CNT_W-1:0] total_count,
  output logic [CNT_W-1:0] mispredict_count,
  output logic             underflow_err
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  logic [IP_W-1:0]  mem_ip [DEPTH];
  logic             mem_pt [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             tv_q, tv_d, tt_q, tt_d, tm_q, tm_d, uf_q, uf_d;
  logic [IP_W-1:0]  tip_q, tip_d;
  logic [CNT_W-1:0] tot_q, tot_d, mis_q, mis_d;
  logic             push, pop, mis;
  assign pred_ready       = cnt_q != FULL;
  assign push             = pred_valid && pred_ready && !flush;
  assign pop              = resolve_valid && cnt_q != '0 && !flush;
  assign mis              = mem_pt[rd_q] ^ resolve_taken;
  assign train_valid      = tv_q;
  assign train_ip         = tip_q;
  assign train_taken      = tt_q;
  assign train_mispredict = tm_q;
  assign occupancy        = cnt_q;
  assign total_count      = tot_q;
  assign mispredict_count = mis_q;
  assign underflow_err    = uf_q;
  always_comb begin
    wr_d  = flush ? '0 : push ? wr_q + PTR_W'(1) : wr_q;
    rd_d  = flush ? '0 : pop ? rd_q + PTR_W'(1) : rd_q;
    cnt_d = flush ? '0 : cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    tv_d  = pop;
    tip_d = pop ? mem_ip[rd_q] : tip_q;
    tt_d  = pop ? resolve_taken : tt_q;
    tm_d  = pop ? mis : tm_q;
    tot_d = (pop && tot_q != '1) ? tot_q + CNT_W'(1) : tot_q;
    mis_d = (pop && mis && mis_q != '1) ? mis_q + CNT_W'(1) : mis_q;
    uf_d  = uf_q || (resolve_valid && cnt_q == '0 && !flush);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      tv_q  <= 1'b0;
      tip_q <= '0;
      tt_q  <= 1'b0;
      tm_q  <= 1'b0;
      tot_q <= '0;
      mis_q <= '0;
      uf_q  <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      tv_q  <= tv_d;
      tip_q <= tip_d;
      tt_q  <= tt_d;
      tm_q  <= tm_d;
      tot_q <= tot_d;
      mis_q <= mis_d;
      uf_q  <= uf_d;
    end
  end
  // entry storage is intentionally left out of reset and flush
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_ip[wr_q] <= pred_ip;
      mem_pt[wr_q] <= pred_taken;
    end
  end
endmodule

// File: tb/tb_branch_resolution_queue.sv
// tb_branch_resolution_queue: directed scoreboard bench for branch_resolution_queue
module tb_branch_resolution_queue;
  logic        clk = 0, reset = 1;
  logic        pred_valid = 0, pred_taken = 0, resolve_valid = 0, resolve_taken = 0, flush = 0;
  logic [63:0] pred_ip = 0;
  logic        pred_ready, train_valid, train_taken, train_mispredict, underflow_err;
  logic [63:0] train_ip;
  logic [3:0]  occupancy;
  logic [31:0] total_count, mispredict_count;
  typedef struct { logic [63:0] ip; logic pt; } ent_t;
  typedef struct { logic [63:0] ip; logic t; logic m; } rec_t;
  ent_t mq[$];
  rec_t sb[$];
  rec_t last;
  int   mtot, mmis, checks, errors;
  logic muf;
  always #5 clk = ~clk;
  branch_resolution_queue dut (
    .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_ip(pred_ip), .pred_taken(pred_taken),
    .pred_ready(pred_ready), .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
    .train_valid(train_valid), .train_ip(train_ip), .train_taken(train_taken),
    .train_mispredict(train_mispredict), .occupancy(occupancy), .total_count(total_count),
    .mispredict_count(mispredict_count), .underflow_err(underflow_err)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_state(input logic rec);
    rec_t r;
    if (rec) begin
      r = sb.pop_front();
      last = r;
    end
    chk("train_valid", train_valid, rec);
    chk("train_ip", train_ip, last.ip);
    chk("train_taken", train_taken, last.t);
    chk("train_mispredict", train_mispredict, last.m);
    chk("occupancy", occupancy, mq.size());
    chk("pred_ready", pred_ready, mq.size() != 8);
    chk("total_count", total_count, mtot);
    chk("mispredict_count", mispredict_count, mmis);
    chk("underflow_err", underflow_err, muf);
  endtask
  task automatic cycle(input logic pv, input logic [63:0] ip, input logic pt,
                       input logic rv, input logic rt, input logic fl);
    ent_t e;
    logic ready, rec;
    pred_valid = pv; pred_ip = ip; pred_taken = pt;
    resolve_valid = rv; resolve_taken = rt; flush = fl;
    ready = mq.size() != 8;
    rec = 0;
    if (fl) mq.delete();
    else begin
      if (rv && mq.size() == 0) muf = 1;
      if (rv && mq.size() != 0) begin
        e = mq.pop_front();
        sb.push_back('{ip: e.ip, t: rt, m: e.pt ^ rt});
        mtot++;
        if (e.pt ^ rt) mmis++;
        rec = 1;
      end
      if (pv && ready) mq.push_back('{ip: ip, pt: pt});
    end
    @(posedge clk); #1;
    pred_valid = 0; resolve_valid = 0; flush = 0;
    check_state(rec);
  endtask
  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    reset = 1; pred_valid = 0; resolve_valid = 0; flush = 0;
    mq.delete(); sb.delete();
    mtot = 0; mmis = 0; muf = 0; last = '{ip: 0, t: 0, m: 0};
    @(posedge clk); #1;
    reset = 0;
    check_state(0);
  endtask
  initial begin
    checks = 0; errors = 0;
    do_reset();
    idle();
    // basic two-branch sequence
    cycle(1, 64'h1000, 1, 0, 0, 0);
    cycle(1, 64'h2000, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    chk("basic_ip0", train_ip, 64'h1000);
    chk("basic_mis0", train_mispredict, 0);
    cycle(0, 0, 0, 1, 1, 0);
    chk("basic_ip1", train_ip, 64'h2000);
    chk("basic_mis1", train_mispredict, 1);
    idle();
    chk("basic_total", total_count, 2);
    chk("basic_miscnt", mispredict_count, 1);
    chk("basic_occ", occupancy, 0);
    // fill, overflow attempt, wrap
    for (int i = 0; i < 8; i++) cycle(1, 64'h10 + i, i[0], 0, 0, 0);
    chk("full_ready", pred_ready, 0);
    chk("full_occ", occupancy, 8);
    cycle(1, 64'h1B, 1, 0, 0, 0);
    chk("drop_occ", occupancy, 8);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, i[1], 0);
    for (int i = 0; i < 3; i++) cycle(1, 64'h18 + i, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 1, 0);
    chk("wrap_last_ip", train_ip, 64'h1A);
    idle();
    // steady-state push/pop at occupancy 4
    for (int i = 0; i < 4; i++) cycle(1, 64'h100 + i, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 64'h200 + i, $urandom_range(0, 1), 1, $urandom_range(0, 1), 0);
      chk("sim_valid", train_valid, 1);
      chk("sim_occ", occupancy, 4);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 0);
    idle();
    // underflow on empty queue
    cycle(0, 0, 0, 1, 1, 0);
    chk("uf_flag", underflow_err, 1);
    chk("uf_tv", train_valid, 0);
    idle();
    idle();
    // flush beats concurrent push and pop
    for (int i = 0; i < 5; i++) cycle(1, 64'h30 + i, 1, 0, 0, 0);
    cycle(1, 64'h99, 1, 1, 0, 1);
    chk("flush_occ", occupancy, 0);
    chk("flush_tv", train_valid, 0);
    cycle(1, 64'h40, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    chk("flush_ip", train_ip, 64'h40);
    idle();
    // reset mid-run with entries in flight
    for (int i = 0; i < 6; i++) cycle(1, 64'h50 + i, 1, 0, 0, 0);
    do_reset();
    idle();
    chk("rst_ready", pred_ready, 1);
    if (sb.size() != 0) chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
